sync_fifo_dp: RTL and testbench

SYNC_FIFO_DP -- requirements
Module: sync_fifo_dp

---
 rtl/sync_fifo_dp.sv | 116 +++++++++++
 tb/tb_sync_fifo_dp.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_dp.sv
// sync_fifo_dp: single-clock FIFO with registered data, occupancy and status flags.
// Ports: clk, rst (sync, active-high), wr_en/din write side, rd_en/dout read side,
//        full/almost_full/empty/almost_empty flags, count occupancy, overflow/underflow pulses.
//        Define FIFO_FWFT_EN for first-word-fall-through; the default build is standard mode.
module sync_fifo_dp #(
    parameter int WD     = 8,
    parameter int DP     = 16,
    parameter int AD     = $clog2(DP),
    parameter int AF_LVL = 2,
    parameter int AE_LVL = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [WD-1:0] din,
    input  logic          rd_en,
    output logic [WD-1:0] dout,
    output logic          full,
    output logic          almost_full,
    output logic          empty,
    output logic          almost_empty,
    output logic [AD:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AD:0] CNT_FULL = (AD+1)'(DP);
    localparam logic [AD:0] CNT_AF   = (AD+1)'(DP - AF_LVL);
    localparam logic [AD:0] CNT_AE   = (AD+1)'(AE_LVL);

    logic [WD-1:0] mem_q [DP];

    logic [AD-1:0] wr_ptr_q, wr_ptr_d;
    logic [AD-1:0] rd_ptr_q, rd_ptr_d;
    logic [AD:0]   count_q, count_d;
    logic [WD-1:0] dout_q, dout_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          empty_q, empty_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_acc;
    logic          rd_acc;

    always_comb begin
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AD'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AD'(1) : rd_ptr_q;
        count_d  = count_q + {{AD{1'b0}}, wr_acc} - {{AD{1'b0}}, rd_acc};
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CNT_AF);
        aempty_d = (count_d <= CNT_AE);
        // A rejected request still reports its error even if the other side moves.
        ovf_d    = wr_en & full_q;
        unf_d    = rd_en & empty_q;
`ifdef FIFO_FWFT_EN
        // dout tracks the head word after this edge; if the only surviving
        // word is the one being written now, it comes straight from din.
        if (count_d == '0) begin
            dout_d = dout_q;
        end else if (wr_acc && (count_q == {{AD{1'b0}}, rd_acc})) begin
            dout_d = din;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
`else
        dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
`endif
    end

    // Storage is never cleared; stale words are unreachable via the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign dout         = dout_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_dp.sv
// tb_sync_fifo_dp: self-checking bench for sync_fifo_dp (DP=16, WD=8).
// Reference is a queue of words plus an occupancy counter kept by the bench.
module tb_sync_fifo_dp;

    localparam int WD = 8;
    localparam int DP = 16;
    localparam int AD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [WD-1:0] din;
    logic          rd_en;
    logic [WD-1:0] dout;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic          almost_empty;
    logic [AD:0]   count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [WD-1:0] sb[$];
    int            m_cnt;
    logic [WD-1:0] m_dout;
    logic [WD-1:0] seq;

    sync_fifo_dp #(.WD(WD), .DP(DP), .AF_LVL(2), .AE_LVL(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input logic e_ovf, input logic e_unf);
        check("count", 32'(count), 32'(m_cnt));
        check("full", 32'(full), 32'(m_cnt == DP));
        check("empty", 32'(empty), 32'(m_cnt == 0));
        check("almost_full", 32'(almost_full), 32'(m_cnt >= DP - 2));
        check("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
        check("overflow", 32'(overflow), 32'(e_ovf));
        check("underflow", 32'(underflow), 32'(e_unf));
        check("dout", 32'(dout), 32'(m_dout));
    endtask

    task automatic step(input logic w, input logic [WD-1:0] d, input logic r);
        logic e_ovf, e_unf, wacc, racc;
        rst   = 1'b0;
        wr_en = w;
        din   = d;
        rd_en = r;
        e_ovf = w && (m_cnt == DP);
        e_unf = r && (m_cnt == 0);
        wacc  = w && (m_cnt < DP);
        racc  = r && (m_cnt > 0);
        if (racc) begin
            logic [WD-1:0] popped;
            popped = sb.pop_front();
`ifndef FIFO_FWFT_EN
            m_dout = popped;
`endif
        end
        if (wacc) sb.push_back(d);
        m_cnt = m_cnt + int'(wacc) - int'(racc);
`ifdef FIFO_FWFT_EN
        if (sb.size() > 0) m_dout = sb[0];
`endif
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(e_ovf, e_unf);
    endtask

    task automatic do_reset(input logic w, input logic r);
        rst   = 1'b1;
        wr_en = w;
        rd_en = r;
        din   = 8'h5A;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sb.delete();
        m_cnt  = 0;
        m_dout = '0;
        check_all(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        m_cnt = 0; m_dout = '0;

        do_reset(1'b0, 1'b0);

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hAB, 1'b1);
        step(1'b1, 8'h10, 1'b0);

        while (m_cnt > 0) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h77, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        seq = 8'h20;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq, 1'b0);
            seq++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, seq, 1'b1);
            seq++;
        end
        while (m_cnt > 0) step(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        do_reset(1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic w, r;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            if (i >= 200) begin
                w = ($urandom_range(0, 99) < 40);
                r = ($urandom_range(0, 99) < 60);
            end
            step(w, 8'($urandom_range(0, 255)), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
